// File: rtl/parking_access_ctrl.sv
// Lot occupancy controller. It decodes the ordered blocking of the outer (a)
// and inner (b) beams into entry and exit commits. It keeps the occupancy count
// within 0..CAPACITY, drives the entry gate request, and pulses reject or error
// when a sequence cannot be honoured.
module parking_access_ctrl #(
    parameter int CAPACITY = 7,
    parameter int CNT_W    = 3,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             gate_open,
    output logic             inc_pulse,
    output logic             dec_pulse,
    output logic             reject,
    output logic             error
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A1,
        S_AB,
        S_B2,
        S_B1,
        S_BA,
        S_A2,
        S_WAIT_CLEAR
    } state_t;

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               inc_reg, inc_next;
    logic               dec_reg, dec_next;
    logic               reject_reg, reject_next;
    logic               error_reg, error_next;

    logic [1:0]         code;
    logic               entry_commit;
    logic               exit_commit;
    logic               in_sequence;

    assign code = {a, b};

    // State, dwell timer, occupancy and event pulses all advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            timer_reg  <= '0;
            count_reg  <= '0;
            inc_reg    <= 1'b0;
            dec_reg    <= 1'b0;
            reject_reg <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            count_reg  <= count_next;
            inc_reg    <= inc_next;
            dec_reg    <= dec_next;
            reject_reg <= reject_next;
            error_reg  <= error_next;
        end
    end

    // Sensor decode, timeout override, commit arithmetic and timer update.
    always_comb begin
        state_next   = state_reg;
        entry_commit = 1'b0;
        exit_commit  = 1'b0;
        error_next   = 1'b0;
        inc_next     = 1'b0;
        dec_next     = 1'b0;
        reject_next  = 1'b0;
        count_next   = count_reg;

        case (state_reg)
            S_IDLE: begin
                if (code == 2'b10)      state_next = S_A1;
                else if (code == 2'b01) state_next = S_B1;
                else if (code == 2'b11) begin state_next = S_WAIT_CLEAR; error_next = 1'b1; end
            end
            S_A1: begin
                if (code == 2'b11)      state_next = S_AB;
                else if (code == 2'b00) state_next = S_IDLE;
                else if (code == 2'b01) begin state_next = S_WAIT_CLEAR; error_next = 1'b1; end
            end
            S_AB: begin
                if (code == 2'b01)      state_next = S_B2;
                else if (code == 2'b10) state_next = S_A1;
                else if (code == 2'b00) begin state_next = S_WAIT_CLEAR; error_next = 1'b1; end
            end
            S_B2: begin
                if (code == 2'b00)      begin state_next = S_IDLE; entry_commit = 1'b1; end
                else if (code == 2'b11) state_next = S_AB;
                else if (code == 2'b10) begin state_next = S_WAIT_CLEAR; error_next = 1'b1; end
            end
            S_B1: begin
                if (code == 2'b11)      state_next = S_BA;
                else if (code == 2'b00) state_next = S_IDLE;
                else if (code == 2'b10) begin state_next = S_WAIT_CLEAR; error_next = 1'b1; end
            end
            S_BA: begin
                if (code == 2'b10)      state_next = S_A2;
                else if (code == 2'b01) state_next = S_B1;
                else if (code == 2'b00) begin state_next = S_WAIT_CLEAR; error_next = 1'b1; end
            end
            S_A2: begin
                if (code == 2'b00)      begin state_next = S_IDLE; exit_commit = 1'b1; end
                else if (code == 2'b11) state_next = S_BA;
                else if (code == 2'b01) begin state_next = S_WAIT_CLEAR; error_next = 1'b1; end
            end
            S_WAIT_CLEAR: begin
                if (code == 2'b00)      state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // A stalled sequence is abandoned; a real transition on the same edge wins.
        in_sequence = (state_reg != S_IDLE) && (state_reg != S_WAIT_CLEAR);
        if (in_sequence && (state_next == state_reg) &&
            (timer_reg == TMR_W'(TIMEOUT - 1))) begin
            state_next = S_WAIT_CLEAR;
            error_next = 1'b1;
        end

        if (entry_commit) begin
            if (count_reg < CNT_W'(CAPACITY)) begin
                count_next = count_reg + CNT_W'(1);
                inc_next   = 1'b1;
            end else begin
                reject_next = 1'b1;
            end
        end
        if (exit_commit) begin
            if (count_reg != '0) begin
                count_next = count_reg - CNT_W'(1);
                dec_next   = 1'b1;
            end else begin
                reject_next = 1'b1;
            end
        end

        if ((state_next != state_reg) || !in_sequence) timer_next = '0;
        else                                           timer_next = timer_reg + TMR_W'(1);
    end

    // Flags and gate request decode straight from registered state and count.
    always_comb begin
        full      = (count_reg == CNT_W'(CAPACITY));
        empty     = (count_reg == '0);
        gate_open = ((state_reg == S_A1) || (state_reg == S_AB) || (state_reg == S_B2)) &&
                    (count_reg != CNT_W'(CAPACITY));
    end

    assign count     = count_reg;
    assign inc_pulse = inc_reg;
    assign dec_pulse = dec_reg;
    assign reject    = reject_reg;
    assign error     = error_reg;

endmodule

// File: doc/parking_access_ctrl.md
Name: parking_access_ctrl

Overview:
- Occupancy controller for the single-lane lot.
- Decodes the ordered blocking of the two beam sensors `a` (outer) and `b` (inner) into committed entry or exit events.
- Owns the occupancy count and enforces capacity; flags full and empty.
- Drives the entry gate and reports aborted or illegal sensor sequences.
- Sits directly after the debouncers and replaces the separate in/out FSMs plus counter clocking with one synchronous controller.

Parameters:
- CAPACITY, 7, maximum occupancy; must satisfy CAPACITY <= 2**CNT_W - 1.
- CNT_W, 3, width of the occupancy count.
- TIMEOUT, 1000, maximum cycles allowed in any single sequence state before abort; TIMEOUT >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  1  debounced outer sensor level; 1 = beam blocked.
- b  input  1  debounced inner sensor level; 1 = beam blocked.
- count  output  CNT_W  current occupancy, registered.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- gate_open  output  1  entry barrier open request.
- inc_pulse  output  1  one-cycle pulse on a committed entry.
- dec_pulse  output  1  one-cycle pulse on a committed exit.
- reject  output  1  one-cycle pulse when an entry is attempted while full, or an exit is attempted while empty.
- error  output  1  one-cycle pulse on an illegal sequence or a timeout.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, sampled on the rising edge.
- Reset values: state=IDLE, count=0, timer=0, inc_pulse=dec_pulse=reject=error=0. Hence full=0, empty=1, gate_open=0.
- Reset mid-sequence: the sequence is discarded and nothing is committed.
- Sensor code ab is sampled each edge.
- States: IDLE, A1, AB, B2 (entry path), B1, BA, A2 (exit path), WAIT_CLEAR.
- Transitions, any code not listed holds the state:
  - IDLE: 10->A1; 01->B1; 11->WAIT_CLEAR + error.
  - A1: 11->AB; 00->IDLE (abort, no event); 01->WAIT_CLEAR + error.
  - AB: 01->B2; 10->A1 (backing out); 00->WAIT_CLEAR + error.
  - B2: 00->IDLE + entry commit; 11->AB; 10->WAIT_CLEAR + error.
  - B1: 11->BA; 00->IDLE (abort); 10->WAIT_CLEAR + error.
  - BA: 10->A2; 01->B1; 00->WAIT_CLEAR + error.
  - A2: 00->IDLE + exit commit; 11->BA; 01->WAIT_CLEAR + error.
  - WAIT_CLEAR: 00->IDLE; otherwise stay. No error repeats while in this state.
- Entry commit:
  - If count < CAPACITY: count+1 and inc_pulse.
  - Else: count unchanged and reject.
- Exit commit:
  - If count > 0: count-1 and dec_pulse.
  - Else: count unchanged and reject.
- Count never wraps in either direction.
- Timing: the commit takes effect at the same edge that samples 00 in B2/A2. count, the pulses and flags reflect it in the following cycle, i.e. latency is 1 cycle from the sample. Pulses last exactly one cycle.
- Timer:
  - Clears on every state change and while in IDLE or WAIT_CLEAR.
  - Otherwise increments each cycle.
  - On the edge where timer == TIMEOUT-1 and the state is unchanged: go to WAIT_CLEAR and pulse error. No count change.
  - A normal transition on that same edge takes priority over the timeout.
- gate_open = state ∈ {A1, AB, B2} and not full. It is combinational from registered state and count, so there is no extra latency.
- At most one of inc_pulse, dec_pulse, reject or error is high in any cycle.
- full and empty are combinational decodes of the registered count.

Test Plan:
- Reset, then ab=10,11,01,00 with each held 3 cycles -> inc_pulse exactly once, 1 cycle after the 00 sample. count=1, empty=0, gate_open high during the 10/11/01 phases.
- 7 entries from reset, then an 8th full sequence -> after 7 entries count=7, full=1; 8th gives reject=1, count stays 7, gate_open stays 0 throughout the 8th.
- From count=2: ab=01,11,10,00 -> dec_pulse once, count=1. Repeat twice more -> count=0 then reject, count stays 0, empty=1.
- Backing out: ab=10,11,10,00 -> no pulses, count unchanged, state back to IDLE.
- Illegal sequence: ab=10 then 01 -> error pulse once; hold 01 for 5 cycles -> no further error; then 00 -> IDLE; a following valid entry commits normally.
- Timeout with TIMEOUT=8: hold ab=10 for 20 cycles -> error on the 8th cycle, no count change, gate_open drops. Separately, assert reset while in B2 and then apply 00 -> no inc_pulse and count=0.
